key_lut_mux: RTL

KEY_LUT_MUX -- requirements
Module: key_lut_mux

---
 rtl/key_lut_pkg.sv | 12 +
 rtl/key_lut_match.sv | 34 +++
 rtl/key_lut_mux.sv | 112 +++++++++++
 3 files changed

// File: rtl/key_lut_pkg.sv
// Shared defaults and index-width helper for the key lookup table.
// Build option: define KEY_LUT_FWD_EN to forward same-cycle table writes into lookups.
package key_lut_pkg;
  localparam int NR_KEY_DEF      = 4;
  localparam int KEY_LEN_DEF     = 2;
  localparam int DATA_LEN_DEF    = 8;
  localparam int HAS_DEFAULT_DEF = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_lut_match.sv
// Combinational match: valid-masked key compare, lowest-index priority, data select.
// Build option KEY_LUT_FWD_EN only affects the table view fed in by the parent.
module key_lut_match
  import key_lut_pkg::*;
#(
  parameter int NR_KEY      = NR_KEY_DEF,
  parameter int KEY_LEN     = KEY_LEN_DEF,
  parameter int DATA_LEN    = DATA_LEN_DEF,
  parameter int HAS_DEFAULT = HAS_DEFAULT_DEF,
  parameter int IDX_W       = idx_w(NR_KEY)
) (
  input  logic [NR_KEY-1:0][KEY_LEN-1:0]  i_key,
  input  logic [NR_KEY-1:0][DATA_LEN-1:0] i_data,
  input  logic [NR_KEY-1:0]               i_vld,
  input  logic [KEY_LEN-1:0]              i_req_key,
  input  logic [DATA_LEN-1:0]             i_default_out,
  output logic                            o_hit,
  output logic [IDX_W-1:0]                o_idx,
  output logic [DATA_LEN-1:0]             o_data
);
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    o_data = (HAS_DEFAULT != 0) ? i_default_out : '0;
    // Scan high to low so the lowest matching index is the last one written.
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (i_vld[i] && (i_key[i] == i_req_key)) begin
        o_hit  = 1'b1;
        o_idx  = IDX_W'(i);
        o_data = i_data[i];
      end
    end
  end
endmodule

// File: rtl/key_lut_mux.sv
// Key lookup table with valid/ready request and registered response.
// Build option: KEY_LUT_FWD_EN makes a same-cycle write visible to the lookup.
module key_lut_mux
  import key_lut_pkg::*;
#(
  parameter  int NR_KEY      = NR_KEY_DEF,
  parameter  int KEY_LEN     = KEY_LEN_DEF,
  parameter  int DATA_LEN    = DATA_LEN_DEF,
  parameter  int HAS_DEFAULT = HAS_DEFAULT_DEF,
  localparam int IDX_W       = idx_w(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_vld,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx
);
  logic [NR_KEY-1:0][KEY_LEN-1:0]  r_key;
  logic [NR_KEY-1:0][DATA_LEN-1:0] r_data;
  logic [NR_KEY-1:0]               r_vld;

  logic [NR_KEY-1:0][KEY_LEN-1:0]  w_key;
  logic [NR_KEY-1:0][DATA_LEN-1:0] w_data;
  logic [NR_KEY-1:0]               w_vld;

  logic                r_rsp_valid;
  logic [DATA_LEN-1:0] r_rsp_data;
  logic                r_rsp_hit;
  logic [IDX_W-1:0]    r_rsp_idx;

  logic                w_acc;
  logic                w_hit;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_LEN-1:0] w_mdata;

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_acc     = req_valid && req_ready;

  // Table view seen by the matcher this cycle.
  always_comb begin
    w_key  = r_key;
    w_data = r_data;
    w_vld  = r_vld;
`ifdef KEY_LUT_FWD_EN
    for (int i = 0; i < NR_KEY; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        w_key[i]  = wr_key;
        w_data[i] = wr_data;
        w_vld[i]  = wr_vld;
      end
    end
`endif
  end

  key_lut_match #(
    .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN),
    .HAS_DEFAULT(HAS_DEFAULT), .IDX_W(IDX_W)
  ) u_match (
    .i_key(w_key), .i_data(w_data), .i_vld(w_vld),
    .i_req_key(req_key), .i_default_out(default_out),
    .o_hit(w_hit), .o_idx(w_idx), .o_data(w_mdata)
  );

  // Out-of-range wr_idx never equals an entry index, so it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key  <= '0;
      r_data <= '0;
      r_vld  <= '0;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          r_key[i]  <= wr_key;
          r_data[i] <= wr_data;
          r_vld[i]  <= wr_vld;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
    end else if (w_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_mdata;
      r_rsp_hit   <= w_hit;
      r_rsp_idx   <= w_idx;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_idx   = r_rsp_idx;
endmodule
